seven_segment_scan_controller: RTL

Time-multiplexes one shared seven-segment decoder across NUM_DIGITS common-anode digits. Holds a double-buffered BCD frame and steps through digits with a guard-blank interval between digits to prevent ghosting. Drives the 4-bit decoder input and the per-digit anode enables. Sits between the application counters/FSMs and the board display pins.

---
 rtl/seven_segment_scan_controller_if.sv | 32 +++
 rtl/seven_segment_scan_controller.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scan_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : seven_segment_scan_controller_if
// Brief    : Host/display bundle for the seven-segment scan controller.
//            The host side (master) supplies the frame and scan control and
//            observes the display drive; the controller is the slave.
// Revision : 1.0 - initial release
// ============================================================================
interface seven_segment_scan_controller_if #(
   parameter int NUM_DIGITS = 4
);
   logic                      enable;
   logic                      load;
   logic [4*NUM_DIGITS-1:0]   value_in;
   logic [NUM_DIGITS-1:0]     blank_mask;
   logic                      lz_suppress;
   logic                      load_ack;
   logic [3:0]                dec;
   logic                      seg_blank;
   logic [NUM_DIGITS-1:0]     digit_en_n;

   modport master (
      output enable, load, value_in, blank_mask, lz_suppress,
      input  load_ack, dec, seg_blank, digit_en_n
   );

   modport slave (
      input  enable, load, value_in, blank_mask, lz_suppress,
      output load_ack, dec, seg_blank, digit_en_n
   );
endinterface
`default_nettype wire

// File: rtl/seven_segment_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : seven_segment_scan_controller
// Brief    : Time-multiplexes one shared BCD seven-segment decoder across
//            NUM_DIGITS common-anode digits with a guard-blank gap between
//            digits. The frame is double-buffered and only swapped at a frame
//            boundary (or while idle) so a displayed frame is never torn.
// Revision : 1.0 - initial release
// ============================================================================
module seven_segment_scan_controller #(
   parameter int NUM_DIGITS   = 4,
   parameter int DRIVE_CYCLES = 50000,
   parameter int BLANK_CYCLES = 2
) (
   input  logic clk,
   input  logic reset,
   seven_segment_scan_controller_if.slave bus
);

   localparam int MAX_CYCLES = (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES : BLANK_CYCLES;
   localparam int TMR_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
   localparam int IDX_W      = $clog2(NUM_DIGITS);

   localparam logic [TMR_W-1:0] BLANK_LAST = TMR_W'(BLANK_CYCLES - 1);
   localparam logic [TMR_W-1:0] DRIVE_LAST = TMR_W'(DRIVE_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_DRIVE = 2'd2
   } state_t;

   // Registered state
   state_t                  state;
   logic [IDX_W-1:0]        idx;
   logic [TMR_W-1:0]        timer;
   logic [4*NUM_DIGITS-1:0] act_val;
   logic [NUM_DIGITS-1:0]   act_mask;
   logic [4*NUM_DIGITS-1:0] pend_val;
   logic [NUM_DIGITS-1:0]   pend_mask;
   logic                    pend_valid;
   logic [3:0]              dec_q;
   logic                    eff_q;      // effective blank of the digit being shown
   logic                    seg_blank_q;
   logic [NUM_DIGITS-1:0]   en_q;
   logic                    ack_q;

   // Next-state values
   state_t                  state_n;
   logic [IDX_W-1:0]        idx_n;
   logic [TMR_W-1:0]        timer_n;
   logic                    commit;
   logic [4*NUM_DIGITS-1:0] frame_val_n;
   logic [NUM_DIGITS-1:0]   frame_mask_n;
   logic [3:0]              dec_n;
   logic                    eff_n;
   logic                    seg_blank_n;
   logic [NUM_DIGITS-1:0]   en_n;

   // Per-digit decode of the frame that will be active after this edge
   logic [3:0]              digit_code [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   digit_zero;
   logic [NUM_DIGITS-1:0]   upper_zero;  // digit i and every digit above it are 0
   logic [3:0]              sel_code;
   logic                    sel_invalid;
   logic                    sel_lz;
   logic                    sel_eff;

   assign frame_val_n  = commit ? pend_val  : act_val;
   assign frame_mask_n = commit ? pend_mask : act_mask;

   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digit_code[gi] = frame_val_n[4*gi +: 4];
      assign digit_zero[gi] = (frame_val_n[4*gi +: 4] == 4'd0);
   end

   // Leading-zero chain from the most significant digit downwards
   always_comb begin
      upper_zero                 = '0;
      upper_zero[NUM_DIGITS-1]   = digit_zero[NUM_DIGITS-1];
      for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
         upper_zero[i] = digit_zero[i] & upper_zero[i+1];
      end
   end

   assign sel_code    = digit_code[idx_n];
   assign sel_invalid = (sel_code > 4'd9);
   assign sel_lz      = bus.lz_suppress && (idx_n != '0) && upper_zero[idx_n];
   assign sel_eff     = frame_mask_n[idx_n] | sel_invalid | sel_lz;

   // Next-state logic: scan sequencing, frame commit and registered output values
   always_comb begin
      state_n     = state;
      idx_n       = idx;
      timer_n     = timer;
      commit      = 1'b0;

      unique case (state)
         ST_IDLE: begin
            commit = pend_valid;
            if (bus.enable) begin
               state_n = ST_BLANK;
               idx_n   = '0;
               timer_n = '0;
            end
         end
         ST_BLANK: begin
            if (timer == BLANK_LAST) begin
               state_n = ST_DRIVE;
               timer_n = '0;
            end else begin
               timer_n = timer + 1'b1;
            end
         end
         ST_DRIVE: begin
            if (timer == DRIVE_LAST) begin
               state_n = ST_BLANK;
               timer_n = '0;
               if (idx == IDX_LAST) begin
                  idx_n  = '0;
                  commit = pend_valid;
               end else begin
                  idx_n  = idx + 1'b1;
               end
            end else begin
               timer_n = timer + 1'b1;
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase

      // Dropping enable darkens the display immediately; an idle cycle may
      // still commit, but a frame wrap that is being abandoned may not.
      if (!bus.enable) begin
         state_n = ST_IDLE;
         idx_n   = '0;
         timer_n = '0;
         if (state != ST_IDLE) begin
            commit = 1'b0;
         end
      end

      dec_n       = dec_q;
      eff_n       = eff_q;
      seg_blank_n = 1'b1;
      en_n        = '1;
      if (state_n == ST_BLANK) begin
         // Decoder input and blank decision are latched on BLANK entry and
         // held through the following DRIVE.
         if (state != ST_BLANK) begin
            dec_n = sel_invalid ? 4'd0 : sel_code;
            eff_n = sel_eff;
         end
      end else if (state_n == ST_DRIVE) begin
         en_n[idx_n] = 1'b0;
         seg_blank_n = eff_q;
      end
   end

   // State, frame buffers and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         idx         <= '0;
         timer       <= '0;
         act_val     <= '0;
         act_mask    <= '1;
         pend_val    <= '0;
         pend_mask   <= '0;
         pend_valid  <= 1'b0;
         dec_q       <= 4'd0;
         eff_q       <= 1'b1;
         seg_blank_q <= 1'b1;
         en_q        <= '1;
         ack_q       <= 1'b0;
      end else begin
         state       <= state_n;
         idx         <= idx_n;
         timer       <= timer_n;
         dec_q       <= dec_n;
         eff_q       <= eff_n;
         seg_blank_q <= seg_blank_n;
         en_q        <= en_n;
         ack_q       <= commit;
         if (commit) begin
            act_val    <= pend_val;
            act_mask   <= pend_mask;
            pend_valid <= 1'b0;
         end
         // A load on the commit edge starts a fresh pending frame.
         if (bus.load) begin
            pend_val   <= bus.value_in;
            pend_mask  <= bus.blank_mask;
            pend_valid <= 1'b1;
         end
      end
   end

   assign bus.load_ack   = ack_q;
   assign bus.dec        = dec_q;
   assign bus.seg_blank  = seg_blank_q;
   assign bus.digit_en_n = en_q;

endmodule
`default_nettype wire
